// File: rtl/hazard_scoreboard.sv
// Hazard scoreboard for a classic 5-stage MIPS-style pipeline.
// Tracks the instructions in EX, MEM and WB. It detects load-use hazards
// against the instruction in ID, where it stalls for one cycle and injects a
// bubble. It also selects the EX operand forwarding sources.
// There is no handshake: every cycle the ID slot is either accepted into EX or
// replaced by a bubble, and the tracking slots always advance.
module hazard_scoreboard #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic [4:0]       id_rd,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             id_regdst,
    input  logic             id_regwrite,
    input  logic             id_memread,
    input  logic             flush,
    input  logic             cnt_clr,
    output logic             stall,
    output logic             bubble,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [CNT_W-1:0] stall_cnt
);

    // Forward-select encodings seen by the EX operand muxes.
    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b01;

    // EX tracking slot
    logic [4:0] r_ex_rs;
    logic [4:0] r_ex_rt;
    logic [4:0] r_ex_dst;
    logic       r_ex_wr;
    logic       r_ex_ld;
    // MEM tracking slot
    logic [4:0] r_mem_dst;
    logic       r_mem_wr;
    logic       r_mem_ld;
    // WB tracking slot
    logic [4:0] r_wb_dst;
    logic       r_wb_wr;
    logic       r_wb_ld;

    logic [CNT_W-1:0] r_stall_cnt;

    logic [4:0] w_id_dst;
    logic       w_id_eff_pre;
    logic       w_load_use;
    logic       w_id_eff;
    logic       w_cnt_full;
    logic       w_mem_fwd_ok;
    logic       w_wb_fwd_ok;

    // The ID destination register and whether the ID slot survives a flush.
    always_comb begin
        w_id_dst     = id_regdst ? id_rd : id_rt;
        w_id_eff_pre = id_valid & ~flush;
    end

    // Load-use detection: a load in EX whose result the ID instruction reads.
    // Register 0 is never a hazard; a flushed ID slot never stalls.
    always_comb begin
        w_load_use = 1'b0;
        if (w_id_eff_pre && r_ex_ld && (r_ex_dst != 5'd0)) begin
            if ((id_uses_rs && (id_rs == r_ex_dst)) ||
                (id_uses_rt && (id_rt == r_ex_dst))) begin
                w_load_use = 1'b1;
            end
        end
        w_id_eff = w_id_eff_pre & ~w_load_use;
    end

    assign stall  = w_load_use;
    assign bubble = w_load_use;

    // Eligibility of each later stage as a forwarding source. A load in MEM
    // has no data yet, so MEM forwards only non-load results. WB forwards both.
    always_comb begin
        w_mem_fwd_ok = r_mem_wr & ~r_mem_ld & (r_mem_dst != 5'd0);
        w_wb_fwd_ok  = r_wb_wr & (r_wb_dst != 5'd0);
    end

    // Operand A select: MEM is younger than WB, so it takes priority.
    always_comb begin
        fwd_a = FWD_RF;
        if (w_mem_fwd_ok && (r_mem_dst == r_ex_rs)) begin
            fwd_a = FWD_MEM;
        end else if (w_wb_fwd_ok && (r_wb_dst == r_ex_rs)) begin
            fwd_a = FWD_WB;
        end
    end

    // Operand B select, same rule applied to rt.
    always_comb begin
        fwd_b = FWD_RF;
        if (w_mem_fwd_ok && (r_mem_dst == r_ex_rt)) begin
            fwd_b = FWD_MEM;
        end else if (w_wb_fwd_ok && (r_wb_dst == r_ex_rt)) begin
            fwd_b = FWD_WB;
        end
    end

    // Slot advance: WB<=MEM, MEM<=EX, and EX takes the ID slot or a bubble.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ex_rs   <= 5'd0;
            r_ex_rt   <= 5'd0;
            r_ex_dst  <= 5'd0;
            r_ex_wr   <= 1'b0;
            r_ex_ld   <= 1'b0;
            r_mem_dst <= 5'd0;
            r_mem_wr  <= 1'b0;
            r_mem_ld  <= 1'b0;
            r_wb_dst  <= 5'd0;
            r_wb_wr   <= 1'b0;
            r_wb_ld   <= 1'b0;
        end else begin
            r_wb_dst  <= r_mem_dst;
            r_wb_wr   <= r_mem_wr;
            r_wb_ld   <= r_mem_ld;
            r_mem_dst <= r_ex_dst;
            r_mem_wr  <= r_ex_wr;
            r_mem_ld  <= r_ex_ld;
            if (w_id_eff) begin
                r_ex_rs  <= id_rs;
                r_ex_rt  <= id_rt;
                r_ex_dst <= w_id_dst;
                r_ex_wr  <= id_regwrite;
                r_ex_ld  <= id_memread;
            end else begin
                r_ex_rs  <= 5'd0;
                r_ex_rt  <= 5'd0;
                r_ex_dst <= 5'd0;
                r_ex_wr  <= 1'b0;
                r_ex_ld  <= 1'b0;
            end
        end
    end

    assign w_cnt_full = &r_stall_cnt;

    // Saturating stall-cycle counter; a clear wins over a same-cycle increment.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (cnt_clr) begin
            r_stall_cnt <= '0;
        end else if (w_load_use && !w_cnt_full) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign stall_cnt = r_stall_cnt;

    // WB load flag is carried for completeness; forwarding from WB ignores it.
    logic w_unused;
    assign w_unused = r_wb_ld;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Testbench for hazard_scoreboard: directed pipeline scenarios plus random
// instruction streams, checked against an instruction-level pipeline model.
module tb_hazard_scoreboard;

    logic        clk;
    logic        rst_n;
    logic        id_valid;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic [4:0]  id_rd;
    logic        id_uses_rs;
    logic        id_uses_rt;
    logic        id_regdst;
    logic        id_regwrite;
    logic        id_memread;
    logic        flush;
    logic        cnt_clr;
    logic        stall;
    logic        bubble;
    logic [1:0]  fwd_a;
    logic [1:0]  fwd_b;
    logic [15:0] stall_cnt;
    logic        stall2;
    logic        bubble2;
    logic [1:0]  fwd_a2;
    logic [1:0]  fwd_b2;
    logic [1:0]  stall_cnt2;

    int total = 0;
    int bad   = 0;

    hazard_scoreboard #(.CNT_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs),
        .id_rt(id_rt), .id_rd(id_rd), .id_uses_rs(id_uses_rs),
        .id_uses_rt(id_uses_rt), .id_regdst(id_regdst),
        .id_regwrite(id_regwrite), .id_memread(id_memread), .flush(flush),
        .cnt_clr(cnt_clr), .stall(stall), .bubble(bubble), .fwd_a(fwd_a),
        .fwd_b(fwd_b), .stall_cnt(stall_cnt)
    );

    hazard_scoreboard #(.CNT_W(2)) u_dut_small (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs),
        .id_rt(id_rt), .id_rd(id_rd), .id_uses_rs(id_uses_rs),
        .id_uses_rt(id_uses_rt), .id_regdst(id_regdst),
        .id_regwrite(id_regwrite), .id_memread(id_memread), .flush(flush),
        .cnt_clr(cnt_clr), .stall(stall2), .bubble(bubble2), .fwd_a(fwd_a2),
        .fwd_b(fwd_b2), .stall_cnt(stall_cnt2)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction-level model: in-flight instructions, index 0 = EX, 1 = MEM,
    // 2 = WB. A bubble is an instruction that reads nothing and writes nothing.
    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] dst;
        logic       wr;
        logic       ld;
    } instr_t;

    instr_t pipe [3];
    int     m_cnt;
    int     m_cnt2;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Where EX would read operand register r from: a non-load result one
    // instruction ahead (MEM), else any result two instructions ahead (WB).
    function automatic logic [1:0] src_of(input logic [4:0] r);
        if (r == 0) return 2'b00;
        if (pipe[1].wr && !pipe[1].ld && pipe[1].dst == r) return 2'b10;
        if (pipe[2].wr && pipe[2].dst == r) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic model_load_use();
        logic live;
        live = id_valid && !flush;
        if (!live || !pipe[0].ld || pipe[0].dst == 0) return 1'b0;
        return (id_uses_rs && id_rs == pipe[0].dst) || (id_uses_rt && id_rt == pipe[0].dst);
    endfunction

    // Drivers
    task automatic drv(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic urs, input logic urt,
                       input logic rdst, input logic rw, input logic mr);
        id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd;
        id_uses_rs = urs; id_uses_rt = urt; id_regdst = rdst;
        id_regwrite = rw; id_memread = mr;
    endtask

    task automatic drv_nop();
        drv(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic drv_lw(input logic [4:0] rt);
        drv(1'b1, 5'd0, rt, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    endtask

    task automatic drv_r(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
        drv(1'b1, rs, rt, rd, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic step_begin();
        @(negedge clk);
    endtask

    // Compare every output against the model, then advance the model.
    task automatic step_end();
        logic   lu;
        instr_t nxt;
        int     max16;
        lu = model_load_use();
        chk("stall", 32'(stall), 32'(lu));
        chk("bubble", 32'(bubble), 32'(lu));
        chk("fwd_a", 32'(fwd_a), 32'(src_of(pipe[0].rs)));
        chk("fwd_b", 32'(fwd_b), 32'(src_of(pipe[0].rt)));
        chk("stall_cnt", 32'(stall_cnt), 32'(m_cnt));
        chk("stall_cnt_small", 32'(stall_cnt2), 32'(m_cnt2));
        chk("stall_small", 32'(stall2), 32'(lu));
        max16 = 65535;
        if (!rst_n) begin
            pipe[0] = '0; pipe[1] = '0; pipe[2] = '0;
            m_cnt = 0; m_cnt2 = 0;
        end else begin
            nxt = '0;
            if (id_valid && !flush && !lu) begin
                nxt.rs  = id_rs;
                nxt.rt  = id_rt;
                nxt.dst = id_regdst ? id_rd : id_rt;
                nxt.wr  = id_regwrite;
                nxt.ld  = id_memread;
            end
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            pipe[0] = nxt;
            if (cnt_clr) begin
                m_cnt = 0; m_cnt2 = 0;
            end else if (lu) begin
                if (m_cnt < max16) m_cnt++;
                if (m_cnt2 < 3) m_cnt2++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        step_begin();
        step_end();
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; cnt_clr = 1'b0;
        drv_nop();
        pipe[0] = '0; pipe[1] = '0; pipe[2] = '0;
        m_cnt = 0; m_cnt2 = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset state
        step_begin();
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_bubble", 32'(bubble), 32'd0);
        chk("rst_fwd_a", 32'(fwd_a), 32'd0);
        chk("rst_fwd_b", 32'(fwd_b), 32'd0);
        chk("rst_cnt", 32'(stall_cnt), 32'd0);
        step_end();

        // Load-use: lw $8; add $9,$8,$1
        drv_lw(5'd8); step();
        drv_r(5'd9, 5'd8, 5'd1);
        step_begin();
        chk("lu_stall", 32'(stall), 32'd1);
        chk("lu_bubble", 32'(bubble), 32'd1);
        step_end();
        step_begin();
        chk("lu_stall_once", 32'(stall), 32'd0);
        step_end();
        drv_nop();
        step_begin();
        chk("lu_fwd_a_wb", 32'(fwd_a), 32'd1);
        chk("lu_fwd_b", 32'(fwd_b), 32'd0);
        chk("lu_cnt", 32'(stall_cnt), 32'd1);
        step_end();
        repeat (3) step();

        // EX/MEM forward: add $3; sub $4,$3,$3
        drv_r(5'd3, 5'd1, 5'd2); step();
        drv_r(5'd4, 5'd3, 5'd3); step();
        drv_nop();
        step_begin();
        chk("mem_fwd_a", 32'(fwd_a), 32'd2);
        chk("mem_fwd_b", 32'(fwd_b), 32'd2);
        chk("mem_fwd_stall", 32'(stall), 32'd0);
        step_end();
        repeat (3) step();

        // Priority: add $5; add $5; or $6,$5,$0
        drv_r(5'd5, 5'd1, 5'd2); step();
        drv_r(5'd5, 5'd2, 5'd1); step();
        drv_r(5'd6, 5'd5, 5'd0); step();
        drv_nop();
        step_begin();
        chk("prio_fwd_a", 32'(fwd_a), 32'd2);
        chk("prio_fwd_b", 32'(fwd_b), 32'd0);
        step_end();
        repeat (3) step();

        // Register 0: lw $0; add $7,$0,$0
        drv_lw(5'd0); step();
        drv_r(5'd7, 5'd0, 5'd0);
        step_begin();
        chk("r0_stall", 32'(stall), 32'd0);
        step_end();
        drv_nop();
        step_begin();
        chk("r0_fwd_a", 32'(fwd_a), 32'd0);
        chk("r0_fwd_b", 32'(fwd_b), 32'd0);
        step_end();
        repeat (3) step();

        // Flush: lw $8 in EX, dependent in ID with flush
        drv_lw(5'd8); step();
        drv_r(5'd9, 5'd8, 5'd8); flush = 1'b1;
        step_begin();
        chk("flush_stall", 32'(stall), 32'd0);
        step_end();
        flush = 1'b0;
        step_begin();
        chk("flush_no_stall_after", 32'(stall), 32'd0);
        chk("flush_bubble_fwd_a", 32'(fwd_a), 32'd0);
        step_end();
        drv_nop();
        step_begin();
        chk("flush_wb_fwd", 32'(fwd_a), 32'd1);
        step_end();
        repeat (3) step();

        // Counter saturation: five load-use stalls
        cnt_clr = 1'b1; step(); cnt_clr = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drv_lw(5'd10); step();
            drv_r(5'd11, 5'd10, 5'd2); step();
            step();
        end
        drv_nop();
        step_begin();
        chk("sat_cnt_small", 32'(stall_cnt2), 32'd3);
        chk("sat_cnt_wide", 32'(stall_cnt), 32'd5);
        step_end();
        // cnt_clr during a stall
        drv_lw(5'd12); step();
        drv_r(5'd13, 5'd1, 5'd12); cnt_clr = 1'b1;
        step_begin();
        chk("clr_in_stall", 32'(stall), 32'd1);
        step_end();
        cnt_clr = 1'b0;
        step_begin();
        chk("clr_cnt_wide", 32'(stall_cnt), 32'd0);
        chk("clr_cnt_small", 32'(stall_cnt2), 32'd0);
        step_end();
        drv_nop();
        repeat (3) step();

        // Mid-operation reset discards tracked instructions
        drv_r(5'd14, 5'd1, 5'd2); step();
        drv_nop(); step();
        rst_n = 1'b0; step();
        rst_n = 1'b1;
        drv_r(5'd15, 5'd14, 5'd14); step();
        drv_nop();
        step_begin();
        chk("rst_mid_fwd_a", 32'(fwd_a), 32'd0);
        chk("rst_mid_fwd_b", 32'(fwd_b), 32'd0);
        chk("rst_mid_cnt", 32'(stall_cnt), 32'd0);
        step_end();

        // Random instruction streams on a small register set
        for (int n = 0; n < 600; n++) begin
            drv(1'($urandom_range(0, 9) != 0),
                5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                5'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
                1'($urandom_range(0, 2) == 0));
            flush   = ($urandom_range(0, 9) == 0);
            cnt_clr = ($urandom_range(0, 39) == 0);
            rst_n   = ($urandom_range(0, 59) != 0);
            step();
        end
        rst_n = 1'b1; flush = 1'b0; cnt_clr = 1'b0;
        drv_nop();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the stall performance counter.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on posedge clk.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port id_valid  input  1  ID-stage slot holds a real instruction.
REQ-005 SHALL have port id_rs  input  5  ID source register rs (IR[25:21]).
REQ-006 SHALL have port id_rt  input  5  ID register rt (IR[20:16]).
REQ-007 SHALL have port id_rd  input  5  ID register rd (IR[15:11]).
REQ-008 SHALL have port id_uses_rs, id_uses_rt  input  1 each  ID instruction reads rs / rt.
REQ-009 SHALL have port id_regdst  input  1  destination select: 0 = rt, 1 = rd.
REQ-010 SHALL have port id_regwrite, id_memread  input  1 each  ID instruction writes a register / is a load.
REQ-011 SHALL have port flush  input  1  taken branch/jump; ID slot is cancelled this cycle.
REQ-012 SHALL have port cnt_clr  input  1  clear stall counter.
REQ-013 SHALL have port stall  output  1  hold PC and IF/ID latch.
REQ-014 SHALL have port bubble  output  1  zero ID/EX control this cycle.
REQ-015 SHALL have port fwd_a, fwd_b  output  2 each  EX operand A/B select: 00 = register file, 10 = MEM result, 01 = WB result.
REQ-016 SHALL have port stall_cnt  output  CNT_W  count of load-use stall cycles.

Function
REQ-017 SHALL compute the ID destination as id_dst = id_regdst ? id_rd : id_rt.
REQ-018 SHALL hold three tracking slots, EX, MEM and WB; EX holds {rs, rt, dst, wr, ld} and MEM/WB hold {dst, wr, ld}.
REQ-019 SHALL advance the slots every cycle (WB<=MEM, MEM<=EX) and never freeze them.
REQ-020 SHALL load the EX slot from ID when id_eff = id_valid & ~flush & ~load_use; otherwise it SHALL load EX with all-zero (bubble).
REQ-021 SHALL assert load_use combinationally when id_eff_pre = id_valid & ~flush, EX.ld=1, EX.dst!=0, and (id_uses_rs & id_rs==EX.dst or id_uses_rt & id_rt==EX.dst).
REQ-022 SHALL drive stall = bubble = load_use, with zero cycles of latency from the inputs.
REQ-023 SHALL force stall=0 when flush=1, even if a load-use condition exists.
REQ-024 SHALL drive fwd_a = 10 when MEM.wr & ~MEM.ld & MEM.dst!=0 & MEM.dst==EX.rs; else 01 when WB.wr & WB.dst!=0 & WB.dst==EX.rs; else 00.
REQ-025 SHALL compute fwd_b identically to fwd_a, using EX.rt.
REQ-026 SHALL give MEM priority over WB when both slots match the same operand.
REQ-027 SHALL never forward or stall on register 0.
REQ-028 SHALL NOT handle WB-to-ID register file bypass; that is done by the register file (write-first).
REQ-029 SHALL increment stall_cnt on each cycle with stall=1, saturate at all-ones, and set it to 0 on cnt_clr; cnt_clr wins over a same-cycle increment.
REQ-030 SHALL derive fwd_a, fwd_b, stall and bubble combinationally from the slot registers and inputs; stall_cnt SHALL be a register.

Reset
REQ-031 SHALL, when rst_n=0 at posedge clk, clear all slots (wr=ld=0, regs=0) and set stall_cnt=0.
REQ-032 SHALL produce stall=0, bubble=0, fwd_a=fwd_b=00 in the cycle following reset.
REQ-033 SHALL discard all tracked instructions on a reset asserted mid-operation; no forwarding to pre-reset instructions occurs afterwards.

Verification
REQ-034 Load-use: lw $8 (memread=1, regdst=0, rt=8), then add $9,$8,$1 -> stall=1 and bubble=1 for exactly 1 cycle; one cycle later fwd_a=01; stall_cnt=1.
REQ-035 EX/MEM forward: add $3 (regdst=1, rd=3), then sub $4,$3,$3 -> in sub's EX cycle fwd_a=10 and fwd_b=10, stall=0.
REQ-036 Priority: add $5, add $5, then or $6,$5,$0 -> fwd_a=10 (MEM beats WB), fwd_b=00.
REQ-037 Register 0: lw $0, then add $7,$0,$0 -> stall=0, fwd_a=fwd_b=00.
REQ-038 Flush: lw $8 in EX, dependent in ID with flush=1 -> stall=0; the next EX slot is a bubble (no forwarding from it).
REQ-039 Counter: CNT_W=2 with 5 load-use stalls -> stall_cnt saturates at 3; pulse cnt_clr during a stall -> stall_cnt=0.
